// File: rtl/sme_param.sv
// Parametrised string matcher: stores a string and a pattern from one byte stream and
// finds the leftmost match, supporting ^, $, . and a single * operator.
module sme_param #(
    parameter int DATA_W    = 8,
    parameter int STR_DEPTH = 32,
    parameter int PAT_DEPTH = 8,
    parameter int IDX_W     = $clog2(STR_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] chardata,
    input  logic              isstring,
    input  logic              ispattern,
    output logic              valid,
    output logic              match,
    output logic [IDX_W-1:0]  match_index,
    output logic              overflow,
    output logic              busy
);
    localparam int PA_W = $clog2(PAT_DEPTH);
    localparam int PI_W = PA_W + 1;
    localparam logic [IDX_W:0] STR_LEN_MAX = (IDX_W+1)'(STR_DEPTH);
    localparam logic [PI_W-1:0] PAT_LEN_MAX = PI_W'(PAT_DEPTH);
    localparam logic [DATA_W-1:0] CH_SPACE  = DATA_W'(8'h20);
    localparam logic [DATA_W-1:0] CH_DOLLAR = DATA_W'(8'h24);
    localparam logic [DATA_W-1:0] CH_STAR   = DATA_W'(8'h2A);
    localparam logic [DATA_W-1:0] CH_DOT    = DATA_W'(8'h2E);
    localparam logic [DATA_W-1:0] CH_CARET  = DATA_W'(8'h5E);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_S, S_LOAD_P, S_SPLIT, S_HEAD, S_TAIL, S_DONE
    } state_t;

    state_t state_reg, state_next;
    logic [IDX_W:0]     str_len_reg, str_len_next;
    logic [PI_W-1:0]    pat_len_reg, pat_len_next;
    logic [IDX_W:0]     s_reg, s_next;
    logic [IDX_W:0]     k_reg, k_next;
    logic [IDX_W:0]     p_reg, p_next;
    logic [PI_W-1:0]    j_reg, j_next;
    logic [PI_W-1:0]    head_len_reg, head_len_next;
    logic               has_star_reg, has_star_next;
    logic               str_ovf_reg, str_ovf_next;
    logic               pat_ovf_reg, pat_ovf_next;
    logic               valid_reg, valid_next;
    logic               match_reg, match_next;
    logic [IDX_W-1:0]   match_index_reg, match_index_next;
    logic               busy_reg, busy_next;
    logic               isstring_d_reg;

    logic [DATA_W-1:0]  str_mem [STR_DEPTH];
    logic [DATA_W-1:0]  pat_mem [PAT_DEPTH];
    logic               str_we, pat_we;
    logic [IDX_W-1:0]   str_waddr;
    logic [PA_W-1:0]    pat_waddr;
    logic [IDX_W:0]     str_base;
    logic [PI_W-1:0]    pat_base;
    logic               load_str, pat_start, pat_app;

    logic [PAT_DEPTH-1:0] is_star;
    logic                 star_found;
    logic [PI_W-1:0]      star_pos;

    logic [DATA_W-1:0]  cur_elem, str_at_k, str_before_k;
    logic [IDX_W-1:0]   k_prev_idx;
    logic               k_lt_l, elem_ok, elem_consume;
    logic [IDX_W-1:0]   idx_now;

    always_ff @(posedge clk) begin
        if (str_we) str_mem[str_waddr] <= chardata;
        if (pat_we) pat_mem[pat_waddr] <= chardata;
    end

    // Only the first '*' inside the loaded pattern acts as the operator.
    genvar gi;
    generate
        for (gi = 0; gi < PAT_DEPTH; gi++) begin : g_star
            assign is_star[gi] = (pat_mem[gi] == CH_STAR) && (PI_W'(gi) < pat_len_reg);
        end
    endgenerate

    always_comb begin
        star_found = 1'b0;
        star_pos   = pat_len_reg;
        for (int i = PAT_DEPTH - 1; i >= 0; i--) begin
            if (is_star[i]) begin
                star_found = 1'b1;
                star_pos   = PI_W'(i);
            end
        end
    end

    // Evaluate the current pattern element at string position k.
    always_comb begin
        cur_elem     = pat_mem[j_reg[PA_W-1:0]];
        str_at_k     = str_mem[k_reg[IDX_W-1:0]];
        k_prev_idx   = k_reg[IDX_W-1:0] - IDX_W'(1);
        str_before_k = str_mem[k_prev_idx];
        k_lt_l       = (k_reg < str_len_reg);
        elem_ok      = 1'b0;
        elem_consume = 1'b0;
        case (cur_elem)
            CH_CARET:  elem_ok = (k_reg == '0) || (str_before_k == CH_SPACE);
            CH_DOLLAR: elem_ok = (k_reg == str_len_reg) || (k_lt_l && (str_at_k == CH_SPACE));
            CH_DOT: begin
                elem_ok      = k_lt_l;
                elem_consume = 1'b1;
            end
            default: begin
                elem_ok      = k_lt_l && (str_at_k == cur_elem);
                elem_consume = 1'b1;
            end
        endcase
        idx_now = (head_len_reg == '0) ? '0 : s_reg[IDX_W-1:0];
    end

    always_comb begin
        state_next       = state_reg;
        str_len_next     = str_len_reg;
        pat_len_next     = pat_len_reg;
        s_next           = s_reg;
        k_next           = k_reg;
        p_next           = p_reg;
        j_next           = j_reg;
        head_len_next    = head_len_reg;
        has_star_next    = has_star_reg;
        str_ovf_next     = str_ovf_reg;
        pat_ovf_next     = pat_ovf_reg;
        match_next       = match_reg;
        match_index_next = match_index_reg;
        str_we           = 1'b0;
        pat_we           = 1'b0;
        str_waddr        = '0;
        pat_waddr        = '0;
        str_base         = isstring_d_reg ? str_len_reg : '0;
        pat_base         = '0;

        load_str  = ((state_reg == S_IDLE) || (state_reg == S_LOAD_S)) && isstring;
        pat_start = ((state_reg == S_IDLE) || (state_reg == S_LOAD_S)) && !isstring && ispattern;
        pat_app   = (state_reg == S_LOAD_P) && ispattern;

        // A string restarts only on an isstring rising edge; otherwise it extends.
        if (load_str) begin
            if (!isstring_d_reg) str_ovf_next = 1'b0;
            if (str_base < STR_LEN_MAX) begin
                str_we       = 1'b1;
                str_waddr    = str_base[IDX_W-1:0];
                str_len_next = str_base + 1'b1;
            end else begin
                str_len_next = str_base;
                str_ovf_next = 1'b1;
            end
        end
        if (pat_start || pat_app) begin
            pat_base = pat_start ? '0 : pat_len_reg;
            if (pat_start) pat_ovf_next = 1'b0;
            if (pat_base < PAT_LEN_MAX) begin
                pat_we       = 1'b1;
                pat_waddr    = pat_base[PA_W-1:0];
                pat_len_next = pat_base + 1'b1;
            end else begin
                pat_len_next = pat_base;
                pat_ovf_next = 1'b1;
            end
        end

        case (state_reg)
            S_IDLE: begin
                if (load_str)       state_next = S_LOAD_S;
                else if (pat_start) state_next = S_LOAD_P;
            end
            S_LOAD_S: begin
                if (pat_start)      state_next = S_LOAD_P;
                else if (!isstring) state_next = S_IDLE;
            end
            S_LOAD_P: begin
                if (!ispattern) state_next = S_SPLIT;
            end
            S_SPLIT: begin
                head_len_next = star_pos;
                has_star_next = star_found;
                s_next        = '0;
                k_next        = '0;
                j_next        = '0;
                if (str_ovf_reg || pat_ovf_reg) begin
                    match_next       = 1'b0;
                    match_index_next = '0;
                    state_next       = S_DONE;
                end else begin
                    state_next = S_HEAD;
                end
            end
            S_HEAD: begin
                if (j_reg == head_len_reg) begin
                    if (has_star_reg) begin
                        p_next     = k_reg;
                        j_next     = head_len_reg + 1'b1;
                        state_next = S_TAIL;
                    end else begin
                        match_next       = 1'b1;
                        match_index_next = idx_now;
                        state_next       = S_DONE;
                    end
                end else if (elem_ok) begin
                    j_next = j_reg + 1'b1;
                    k_next = k_reg + {{IDX_W{1'b0}}, elem_consume};
                end else if (s_reg == str_len_reg) begin
                    match_next       = 1'b0;
                    match_index_next = '0;
                    state_next       = S_DONE;
                end else begin
                    s_next = s_reg + 1'b1;
                    k_next = s_reg + 1'b1;
                    j_next = '0;
                end
            end
            S_TAIL: begin
                // A later head start could only move e right, so failure here is final.
                if (j_reg == pat_len_reg) begin
                    match_next       = 1'b1;
                    match_index_next = idx_now;
                    state_next       = S_DONE;
                end else if (elem_ok) begin
                    j_next = j_reg + 1'b1;
                    k_next = k_reg + {{IDX_W{1'b0}}, elem_consume};
                end else if (p_reg == str_len_reg) begin
                    match_next       = 1'b0;
                    match_index_next = '0;
                    state_next       = S_DONE;
                end else begin
                    p_next = p_reg + 1'b1;
                    k_next = p_reg + 1'b1;
                    j_next = head_len_reg + 1'b1;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase

        valid_next = (state_next == S_DONE);
        busy_next  = (state_next == S_SPLIT) || (state_next == S_HEAD) || (state_next == S_TAIL);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= S_IDLE;
            str_len_reg     <= '0;
            pat_len_reg     <= '0;
            s_reg           <= '0;
            k_reg           <= '0;
            p_reg           <= '0;
            j_reg           <= '0;
            head_len_reg    <= '0;
            has_star_reg    <= 1'b0;
            str_ovf_reg     <= 1'b0;
            pat_ovf_reg     <= 1'b0;
            valid_reg       <= 1'b0;
            match_reg       <= 1'b0;
            match_index_reg <= '0;
            busy_reg        <= 1'b0;
            isstring_d_reg  <= 1'b0;
        end else begin
            state_reg       <= state_next;
            str_len_reg     <= str_len_next;
            pat_len_reg     <= pat_len_next;
            s_reg           <= s_next;
            k_reg           <= k_next;
            p_reg           <= p_next;
            j_reg           <= j_next;
            head_len_reg    <= head_len_next;
            has_star_reg    <= has_star_next;
            str_ovf_reg     <= str_ovf_next;
            pat_ovf_reg     <= pat_ovf_next;
            valid_reg       <= valid_next;
            match_reg       <= match_next;
            match_index_reg <= match_index_next;
            busy_reg        <= busy_next;
            isstring_d_reg  <= isstring;
        end
    end

    assign valid       = valid_reg;
    assign match       = match_reg;
    assign match_index = match_index_reg;
    assign overflow    = str_ovf_reg | pat_ovf_reg;
    assign busy        = busy_reg;

endmodule

// File: tb/tb_sme_param.sv
// Scoreboard bench for sme_param: a default instance plus a 64/16 instance.
module tb_sme_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [7:0] cd_a, cd_b;
    logic       is_a, ip_a, is_b, ip_b;
    logic       valid_a, match_a, ovf_a, busy_a;
    logic [4:0] idx_a;
    logic       valid_b, match_b, ovf_b, busy_b;
    logic [5:0] idx_b;

    sme_param dut_a (
        .clk(clk), .reset(reset), .chardata(cd_a), .isstring(is_a), .ispattern(ip_a),
        .valid(valid_a), .match(match_a), .match_index(idx_a), .overflow(ovf_a), .busy(busy_a)
    );

    sme_param #(.DATA_W(8), .STR_DEPTH(64), .PAT_DEPTH(16)) dut_b (
        .clk(clk), .reset(reset), .chardata(cd_b), .isstring(is_b), .ispattern(ip_b),
        .valid(valid_b), .match(match_b), .match_index(idx_b), .overflow(ovf_b), .busy(busy_b)
    );

    typedef struct {
        bit m;
        int idx;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   n_vec = 0;
    int   n_miss = 0;
    int   cyc = 0;
    int   fall_a = 0;
    int   fall_b = 0;
    localparam int BOUND_A = (32 + 1) * (8 + 1) + 3;
    localparam int BOUND_B = (64 + 1) * (16 + 1) + 3;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (valid_a) begin
            if (qa.size() == 0) begin
                check("spurious_valid_a", int'(valid_a), 0);
            end else begin
                ea = qa.pop_front();
                $display("A result: match=%0d idx=%0d (want %0d/%0d) latency=%0d",
                         match_a, idx_a, ea.m, ea.idx, cyc - fall_a);
                check("match_a", int'(match_a), int'(ea.m));
                check("index_a", int'(idx_a), ea.idx);
                check("busy_at_valid_a", int'(busy_a), 0);
                check("latency_within_bound_a", int'((cyc - fall_a) <= BOUND_A), 1);
            end
        end
        if (valid_b) begin
            if (qb.size() == 0) begin
                check("spurious_valid_b", int'(valid_b), 0);
            end else begin
                eb = qb.pop_front();
                $display("B result: match=%0d idx=%0d (want %0d/%0d) latency=%0d",
                         match_b, idx_b, eb.m, eb.idx, cyc - fall_b);
                check("match_b", int'(match_b), int'(eb.m));
                check("index_b", int'(idx_b), eb.idx);
                check("busy_at_valid_b", int'(busy_b), 0);
                check("latency_within_bound_b", int'((cyc - fall_b) <= BOUND_B), 1);
            end
        end
    end

    task automatic drive(input bit inst, input logic [7:0] c, input bit s, input bit p);
        @(posedge clk);
        #1;
        if (inst) begin
            cd_b = c; is_b = s; ip_b = p;
        end else begin
            cd_a = c; is_a = s; ip_a = p;
        end
    endtask

    task automatic load_string(input bit inst, input string s);
        for (int i = 0; i < s.len(); i++) drive(inst, s[i], 1'b1, 1'b0);
        drive(inst, 8'h00, 1'b0, 1'b0);
    endtask

    // Pushes the expectation (if any), streams the pattern, and checks busy rises.
    task automatic send_pattern(input bit inst, input string p, input bit want, input bit m, input int idx);
        exp_t e;
        e.m = m;
        e.idx = idx;
        if (want) begin
            if (inst) qb.push_back(e);
            else      qa.push_back(e);
        end
        for (int i = 0; i < p.len(); i++) drive(inst, p[i], 1'b0, 1'b1);
        drive(inst, 8'h00, 1'b0, 1'b0);
        if (inst) fall_b = cyc;
        else      fall_a = cyc;
        @(posedge clk);
        @(negedge clk);
        if (inst) check("busy_after_pattern_b", int'(busy_b), 1);
        else      check("busy_after_pattern_a", int'(busy_a), 1);
    endtask

    task automatic wait_done(input bit inst);
        int left;
        left = 0;
        for (int i = 0; i < 3000; i++) begin
            left = inst ? qb.size() : qa.size();
            if (left == 0) break;
            @(negedge clk);
        end
        left = inst ? qb.size() : qa.size();
        if (left != 0) begin
            check("result_timeout", left, 0);
            if (inst) qb.delete();
            else      qa.delete();
        end
    endtask

    task automatic pat(input string p, input bit m, input int idx);
        send_pattern(1'b0, p, 1'b1, m, idx);
        wait_done(1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string s;
        reset = 1'b0;
        cd_a = '0; is_a = 1'b0; ip_a = 1'b0;
        cd_b = '0; is_b = 1'b0; ip_b = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_valid", int'(valid_a), 0);
        check("reset_match", int'(match_a), 0);
        check("reset_index", int'(idx_a), 0);
        check("reset_overflow", int'(ovf_a), 0);
        check("reset_busy", int'(busy_a), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        load_string(1'b0, "hello world");
        pat("wor", 1'b1, 6);
        check("overflow_clear_normal", int'(ovf_a), 0);
        pat("^w.rld$", 1'b1, 6);
        pat("^orl", 1'b0, 0);
        pat("$", 1'b1, 5);
        pat("*", 1'b1, 0);
        pat("h*o w", 1'b1, 0);
        pat("l*d$", 1'b1, 2);
        pat("o*z", 1'b0, 0);
        pat("*rl", 1'b1, 0);

        pat("abcdefghi", 1'b0, 0);
        check("overflow_pattern", int'(ovf_a), 1);
        pat("hello", 1'b1, 0);
        check("overflow_cleared_by_pattern", int'(ovf_a), 0);

        load_string(1'b0, "xa*b");
        pat("a**b", 1'b1, 1);

        s = "";
        for (int i = 0; i < 32; i++) s = {s, "a"};
        load_string(1'b0, s);
        @(negedge clk);
        check("overflow_exact_depth", int'(ovf_a), 0);
        pat("a$", 1'b1, 31);

        load_string(1'b0, {s, "a"});
        @(negedge clk);
        check("overflow_string_33", int'(ovf_a), 1);
        pat("a", 1'b0, 0);
        check("overflow_sticky_after_search", int'(ovf_a), 1);
        load_string(1'b0, "hello world");
        @(negedge clk);
        check("overflow_cleared_by_string", int'(ovf_a), 0);

        // Abort a long HEAD search with reset; no result may appear.
        load_string(1'b0, s);
        send_pattern(1'b0, "aaaaaaab", 1'b0, 1'b0, 0);
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b0;
        cd_a = '0; is_a = 1'b0; ip_a = 1'b0;
        #1;
        check("reset_mid_search_busy", int'(busy_a), 0);
        check("reset_mid_search_valid", int'(valid_a), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        pat("^", 1'b1, 0);
        pat(".", 1'b0, 0);
        pat("*$", 1'b1, 0);

        s = "";
        for (int i = 0; i < 20; i++) s = {s, "q"};
        s = {s, "abc"};
        for (int i = 0; i < 27; i++) s = {s, "q"};
        s = {s, "abcdefghij"};
        load_string(1'b1, s);
        send_pattern(1'b1, "abc.efghij$$$$$$", 1'b1, 1'b1, 50);
        wait_done(1'b1);
        check("overflow_b", int'(ovf_b), 0);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/sme_param.md
# sme_param

Parametrised string-matching engine, successor to the fixed 32-char/8-char matcher. It stores one string and one pattern from a shared byte stream and searches the stored string for the leftmost match. Supported pattern operators are `^`, `$`, `.` and, new in this generation, a single `*`. It reports one result per pattern and keeps the stored string across patterns. Depths, the overflow flag and the busy flag are new.

## Interface
- DATA_W, 8, character width (bits)
- STR_DEPTH, 32, max string length (power of 2, ≥4)
- PAT_DEPTH, 8, max pattern length including operators (≥2)
- IDX_W, $clog2(STR_DEPTH), index width (derived, do not override)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- chardata  in  DATA_W  character, sampled in any cycle where isstring or ispattern is high
- isstring  in  1  chardata is a string character
- ispattern  in  1  chardata is a pattern character (mutually exclusive with isstring)
- valid  out  1  single-cycle result strobe
- match  out  1  pattern found; held until the next valid
- match_index  out  IDX_W  string index where the match begins; held until the next valid
- overflow  out  1  sticky; the current string or pattern exceeded its depth
- busy  out  1  search in progress

## Operation
- States:
  - IDLE: on isstring go to LOAD_S (clears string length). On ispattern go to LOAD_P (clears pattern length).
  - LOAD_S: stores the character at the current length and increments the length. isstring low with ispattern high goes to LOAD_P; both low go to IDLE.
  - LOAD_P: stores the character the same way. When ispattern drops, go to SPLIT.
  - SPLIT (1 cycle): locates `*`, giving head = pattern before `*` and tail = pattern after `*`. With no `*`, head is the whole pattern and tail is empty.
  - HEAD: tries start positions s = 0..L, comparing one pattern element per cycle.
  - TAIL: tries positions p = e..L in ascending order, where e is the position just after the matched head.
  - DONE: pulses valid, then returns to IDLE.
- A new string starts only on an isstring rising edge, i.e. the previous cycle had isstring low. The old string is replaced. Patterns always replace the old pattern.
- Element semantics. Position k lies between characters, with 0 ≤ k ≤ L.
  - `.` (0x2E) consumes any one character, including space.
  - A literal consumes one character equal to itself.
  - `^` (0x5E) is zero-width; it holds if k==0 or str[k-1]==0x20.
  - `$` (0x24) is zero-width; it holds if k==L or str[k]==0x20.
  - `*` (0x2A) matches zero or more characters. Only the first `*` is an operator; any later `*` is a literal.
- Head failure at s advances to s+1. Head exhausted beyond s=L gives match=0.
- Tail failure at every p ≥ e gives match=0. No head retry is needed, because any later head start yields a later e.
- match_index:
  - normally the first position consumed by the head, i.e. s after the leading zero-width elements;
  - 0 if the head is empty.
- Overflow:
  - Characters beyond STR_DEPTH or PAT_DEPTH are dropped and overflow is set.
  - The next search goes straight to DONE with match=0 and match_index=0.
  - overflow clears when a new string or pattern load starts.
- Inputs while busy: isstring and ispattern are ignored and chardata is discarded. The environment must not drive them.
- All comparisons are DATA_W wide. Index and length counters are IDX_W+1 bits wide so that length STR_DEPTH is representable.

## Timing
- Reset, asynchronous, all registers:
  - valid=0, match=0, match_index=0, overflow=0, busy=0
  - state=IDLE, string length=0, pattern length=0
- Reset mid-search aborts the search with no valid pulse; busy=0 immediately.
- A pattern against an empty string matches only if it consists solely of `^`, `$` and `*`.
- Load: one character per cycle, zero bubbles.
- busy rises the cycle after ispattern falls and falls in the same cycle valid is high.
- Each HEAD/TAIL step costs 1 cycle per element compared, plus 1 cycle per position advance.
- Worst-case latency from ispattern falling to valid is ≤ (STR_DEPTH+1)·(PAT_DEPTH+1)+3 cycles.
- valid is high for exactly one cycle. match and match_index are stable from that cycle until the next valid.
- A new isstring or ispattern may arrive in the cycle after valid.

## Test plan
1. Load string "hello world" (L=11), pattern "wor" -> valid once, match=1, match_index=6, busy low after valid.
2. Same string retained, patterns `^w.rld$` then `^orl` -> first gives match=1, idx=6; second gives match=0, idx=0.
3. Star patterns on "hello world":
   - "h*o w" -> match=1, idx=0
   - "l*d$" -> match=1, idx=2
   - "o*z" -> match=0
   - "*rl" -> match=1, idx=0
4. Load 33 characters with STR_DEPTH=32, then pattern "a" -> overflow=1 after char 33; result valid with match=0; overflow clears when the next isstring rises.
5. Assert reset during a HEAD search of a 32-char string -> busy=0 and valid=0 immediately; no valid pulse afterwards; pattern "^" on the empty string then gives match=1, idx=0.
6. Rebuild with STR_DEPTH=64, PAT_DEPTH=16; 60-char string with the target at index 50, 16-element pattern -> match=1, match_index=50, latency within the bound.
